// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply/divide unit (radix-2 Booth MULT, restoring DIV)
// Results appear on hi_out/lo_out only at completion; working registers stay internal.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mult_start,
    input  logic             div_start,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    // acc_hi_q carries one guard bit so Booth adds of the most negative operand cannot overflow
    logic [WIDTH:0]   acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             q1_q;
    logic [WIDTH-1:0] m_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_hi_d;
    logic [WIDTH-1:0] booth_lo_d;
    logic             booth_q1_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   div_rem_d;
    logic [WIDTH-1:0] div_quo_d;
    logic [WIDTH-1:0] div_quo_fin;
    logic [WIDTH-1:0] div_rem_fin;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_iter;

    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        booth_sum = acc_hi_q;
        case ({acc_lo_q[0], q1_q})
            2'b01:   booth_sum = acc_hi_q + m_ext;
            2'b10:   booth_sum = acc_hi_q - m_ext;
            default: booth_sum = acc_hi_q;
        endcase
        booth_hi_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo_d = {booth_sum[0], acc_lo_q[WIDTH-1:1]};
        booth_q1_d = acc_lo_q[0];

        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        if (!div_diff[WIDTH]) begin
            div_rem_d = div_diff;
            div_quo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_d = div_shift;
            div_quo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        div_quo_fin = neg_q_q ? -div_quo_d : div_quo_d;
        div_rem_fin = neg_r_q ? -div_rem_d[WIDTH-1:0] : div_rem_d[WIDTH-1:0];

        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mult_start) begin
                        acc_hi_q <= '0;
                        acc_lo_q <= b;
                        q1_q     <= 1'b0;
                        m_q      <= a;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_MULT;
                    end else if (div_start) begin
                        if (b == '0) begin
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            acc_hi_q <= '0;
                            acc_lo_q <= a_mag;
                            m_q      <= b_mag;
                            neg_q_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r_q  <= a[WIDTH-1];
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    acc_hi_q <= booth_hi_d;
                    acc_lo_q <= booth_lo_d;
                    q1_q     <= booth_q1_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_iter) begin
                        hi_q    <= booth_hi_d[WIDTH-1:0];
                        lo_q    <= booth_lo_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                S_DIV: begin
                    acc_hi_q <= div_rem_d;
                    acc_lo_q <= div_quo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_iter) begin
                        hi_q    <= div_rem_fin;
                        lo_q    <= div_quo_fin;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - table-driven self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fail = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .mult_start(mult_start), .div_start(div_start),
        .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // op: 0 = mult_start, 1 = div_start, 2 = both together
    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input int op, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int lat;
        int busy_n;
        @(negedge clk);
        a = ta;
        b = tb_v;
        mult_start = (op != 1);
        div_start  = (op != 0);
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        busy_n = 0;
        while (!done && lat < 50) begin
            busy_n += int'(busy);
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), edz ? 32'd0 : 32'd32);
        check({nm, " busy_cycles"}, 32'(busy_n), edz ? 32'd0 : 32'd32);
        check({nm, " hi_out"}, hi_out, ehi);
        check({nm, " lo_out"}, lo_out, elo);
        check({nm, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        @(posedge clk);
        #1;
        check({nm, " done_one_cycle"}, {31'd0, done}, 32'd0);
        check({nm, " busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int early_done;
        int late_done;

        tbl[0]  = '{0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[2]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tbl[3]  = '{0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        tbl[4]  = '{1, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[5]  = '{1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[6]  = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[7]  = '{1, 32'd100,       32'd7,         32'h00000002, 32'h0000000E, 1'b0};
        tbl[8]  = '{1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        tbl[9]  = '{2, 32'd3,         32'd4,         32'h00000000, 32'h0000000C, 1'b0};
        tbl[10] = '{1, 32'd5,         32'd0,         32'h00000000, 32'h0000000C, 1'b1};
        tbl[11] = '{0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset hi_out", hi_out, 32'd0);
        check("reset lo_out", lo_out, 32'd0);
        check("reset flags", {29'd0, busy, done, div_zero}, 32'd0);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz);

        // mid-operation starts ignored, then reset aborts the multiply
        @(negedge clk);
        a = 32'd5;
        b = 32'd6;
        mult_start = 1'b1;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        early_done = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) early_done++;
            mult_start = (k == 10);
            div_start  = (k == 10);
            if (k == 10) b = 32'd0;
            reset = (k == 20);
        end
        @(negedge clk);
        reset = 1'b0;
        mult_start = 1'b0;
        div_start = 1'b0;
        check("abort early_done", 32'(early_done), 32'd0);
        check("abort hi_out", hi_out, 32'd0);
        check("abort lo_out", lo_out, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        late_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        check("abort no_done", 32'(late_done), 32'd0);

        run_op("post_reset_mult", 0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit for the multicycle CPU datapath; it executes MULT and DIV.
- Operands come from the A/B registers. Results go into HI/LO, which the control unit commits with hi_w/lo_w.
- The control unit starts an operation with a one-cycle pulse and waits for done before advancing. div_zero feeds the exception path (epc_w).

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand A (multiplicand / dividend), signed two's complement.
- b  in  WIDTH  operand B (multiplier / divisor), signed two's complement.
- mult_start  in  1  one-cycle request for a signed multiply.
- div_start  in  1  one-cycle request for a signed divide.
- hi_out  out  WIDTH  MULT: upper product half. DIV: remainder.
- lo_out  out  WIDTH  MULT: lower product half. DIV: quotient.
- busy  out  1  high while an operation is in progress (MULT or DIV state).
- done  out  1  one-cycle pulse: result (or div_zero) is valid.
- div_zero  out  1  one-cycle pulse coincident with done when DIV had b == 0.

Behaviour:
- One clock domain (clk). reset is synchronous and active-high.
- Reset: state=IDLE, counter=0, internal registers=0, hi_out=lo_out=0, busy=done=div_zero=0. Reset asserted mid-operation aborts it; no done is produced.
- States: IDLE, MULT, DIV, FINISH.
- IDLE
  - On edge N with mult_start=1: latch a/b, counter=0, go to MULT.
  - Else on edge N with div_start=1 and b!=0: latch |a|, |b| and the sign bits, counter=0, go to DIV.
  - Both starts high on the same edge: mult wins; div_start is ignored.
  - div_start with b==0: go straight to FINISH. done=div_zero=1 during the cycle after edge N. hi_out/lo_out stay unchanged.
- MULT
  - Radix-2 Booth over a 2*WIDTH+1-bit accumulator {hi, lo, q-1}.
  - One add/sub plus arithmetic right shift per edge; counter increments each edge.
  - After WIDTH iterations (edges N+1..N+WIDTH), the edge N+WIDTH loads hi_out/lo_out and goes to FINISH.
- DIV
  - Restoring unsigned division on the magnitudes, one quotient bit per edge, WIDTH iterations (edges N+1..N+WIDTH).
  - On edge N+WIDTH, signs are applied:
    - quotient is negated if sign(a) xor sign(b), truncating toward zero;
    - remainder takes sign(a).
  - Results load into lo_out/hi_out; go to FINISH.
  - 0x80000000 / -1 gives lo_out=0x80000000, hi_out=0 (wraps, no flag).
- FINISH
  - done=1 for exactly one cycle (N+WIDTH .. N+WIDTH+1), busy=0. Next edge returns to IDLE.
  - done is therefore visible WIDTH cycles after the start edge (32 for default).
- Timing
  - busy=1 only in MULT/DIV. Starts seen while busy or in FINISH are ignored, not queued.
  - A new start may be accepted on the edge FINISH→IDLE is taken? No: it is accepted only in IDLE, so back-to-back operations are spaced WIDTH+2 edges apart.
- Outputs
  - hi_out/lo_out hold their last result until the next successful completion or reset. Partial values never appear on them; working registers are internal.
  - done and div_zero are registered outputs (no combinational path from the start inputs).
  - a/b may change after the start edge without affecting the operation in progress.

Test Plan:
- Reset, then mult_start with a=7, b=0xFFFFFFFD (-3) → done exactly 32 cycles after the start edge. hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB. busy high for 32 cycles.
- MULT a=b=0x80000000 → hi_out=0x40000000, lo_out=0x00000000. MULT a=0xFFFFFFFF, b=0xFFFFFFFF → hi_out=0, lo_out=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1).
- DIV a=7, b=0xFFFFFFFE (-2) → lo_out=0xFFFFFFFD, hi_out=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo_out=0x80000000, hi_out=0.
- Preload hi_out/lo_out via a MULT, then div_start with b=0 → done=div_zero=1 on the next cycle only. hi_out/lo_out unchanged. busy never asserts.
- Start MULT 5*6; pulse mult_start and div_start again at cycle 10; assert reset at cycle 20 → the mid-op starts are ignored. After reset: hi_out=lo_out=0, busy=0, no done pulse. A fresh MULT 5*6 then yields lo_out=30, hi_out=0.
- Assert mult_start and div_start together with a=3, b=4 → MULT is performed: lo_out=12, hi_out=0, div_zero=0.
